// File: rtl/mult_job_sequencer.sv
// Initiator-side sequencer for the 8x8 sequential multiplier core: one start pulse per job,
// operands held until done, timeout with bounded retry, sticky error and a result stream.
module mult_job_sequencer #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int MAX_RETRY      = 1
) (
    input  logic                  clk,
    input  logic                  reset_a,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    output logic                  mult_start,
    output logic [DATA_W-1:0]     mult_dataa,
    output logic [DATA_W-1:0]     mult_datab,
    input  logic                  mult_done,
    input  logic [2*DATA_W-1:0]   mult_product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_product,
    output logic                  busy,
    output logic                  err,
    input  logic                  clr_err,
    output logic [7:0]            job_count
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TIMER_W-1:0]   timer;
    logic [RETRY_W-1:0]   retry;
    logic                 accept;
    logic                 capture;
    logic                 retry_go;
    logic                 timeout;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // mult_done priority over the timeout falls out of the if/else order in WAIT
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        retry_go   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mult_done) begin
                    capture    = 1'b1;
                    state_next = OUT;
                end else if (timer == TIMER_LAST) begin
                    if (retry < RETRY_MAX) begin
                        retry_go   = 1'b1;
                        state_next = START;
                    end else begin
                        timeout    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // mult_start is registered from the next state so it is high exactly while in START
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            mult_start  <= 1'b0;
            mult_dataa  <= '0;
            mult_datab  <= '0;
            timer       <= '0;
            retry       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            err         <= 1'b0;
            job_count   <= '0;
        end else begin
            mult_start <= (state_next == START);

            if (accept) begin
                mult_dataa <= in_a;
                mult_datab <= in_b;
                retry      <= '0;
            end else if (retry_go) begin
                retry <= retry + RETRY_W'(1);
            end

            if (state == START) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TIMER_W'(1);
            end

            if (capture) begin
                out_product <= mult_product;
                out_valid   <= 1'b1;
                job_count   <= job_count + 8'd1;
            end else if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
            end

            err <= timeout | (err & ~clr_err);
        end
    end

endmodule
